tx_block_gearbox: RTL and testbench
===================================

# tx_block_gearbox

Per-lane 128b/130b transmit gearbox for the PCIe Gen3 PHY TX path. It takes one 8-bit symbol per cycle, along with start-block and sync-header qualifiers from the lane framing logic. It inserts the 2-bit sync header ahead of each 16-symbol block and packs the resulting bitstream into fixed 8-bit words for the serializer. It is the transmit counterpart of the RX block aligner, which strips those same headers. Instantiated once per lane under the PHY TX top.

## Interface
- SYMBOL_WIDTH, 8, symbol and output word width.
- SYNC_WIDTH, 2, sync header width.
- BLOCK_SYMBOLS, 16, symbols per 128b/130b block.
- ACC_WIDTH, 24, accumulator width in bits.

Ports:
- CLK  in  1  clock; single clock domain.
- RST_L  in  1  reset, asynchronous, active-low.
- i_GEN  in  1  1 = Gen3 (128b/130b), 0 = Gen1/2 pass-through. Quasi-static; change only with i_Soft_RST.
- i_Soft_RST  in  1  synchronous clear of all state.
- i_Valid  in  1  i_Symbol is valid.
- i_Symbol  in  8  symbol; bit 0 is transmitted first.
- i_Start_Block  in  1  first symbol of a block (Gen3 only).
- i_Sync_Header  in  2  header for this block; bit 0 is transmitted first. Legal values are SYNC_DATA=2'b10 and SYNC_OS=2'b01.
- o_Data  out  8  output word; bit 0 is the earliest bit on the wire.
- o_Valid  out  1  o_Data is valid.
- o_Back_Pressure  out  1  the symbol presented this cycle is not accepted.
- o_Error  out  1  one-cycle framing error pulse.

## Operation
- Accept = i_Valid & ~o_Back_Pressure.
- Append width:
  - Gen3 and i_Start_Block: 10 bits, {header, symbol}, with the header bits first.
  - Otherwise: 8 bits.
- The accumulator is LSB-first. New bits are appended at position fill_q. Emitting shifts the accumulator down by 8.
- Emit = (fill_q ≥ 8).
- fill_d = fill_q − (emit ? 8 : 0) + (accept ? append width : 0).
- fill_q maximum is 17 and must never exceed ACC_WIDTH.
- o_Back_Pressure = i_GEN & (fill_q ≥ 16). This is a flop-derived output with no combinational path from any input.
- o_Data = acc_q[7:0]; o_Valid = emit. Both are taken directly from flops.
- Symbol counter sym_cnt (0..15) is Gen3 only and advances on every accept, wrapping 15→0.
  - i_Start_Block with sym_cnt ≠ 0: o_Error. The header is still inserted and sym_cnt realigns to 1.
  - Accept at sym_cnt = 0 without i_Start_Block: o_Error. The symbol is appended as 8 bits and sym_cnt advances.
  - i_Start_Block with a sync header not in {01, 10}: o_Error. The header is transmitted unchanged.
- Gaps (i_Valid = 0) are allowed anywhere. The block holds sym_cnt and keeps draining while fill_q ≥ 8.
- Gen1/2 (i_GEN = 0): i_Start_Block and i_Sync_Header are ignored. fill_q stays ≤ 8, o_Back_Pressure stays 0, and o_Error stays 0.
- Steady Gen3 traffic: 4 blocks (64 symbols, 520 bits) produce 65 words, with exactly one back-pressure cycle per 4 blocks.

## Timing
- Reset (RST_L low, or i_Soft_RST at the clock edge):
  - acc_q = 0, fill_q = 0, sym_cnt = 0.
  - o_Data = 0, o_Valid = 0, o_Back_Pressure = 0, o_Error = 0.
- Latency: a symbol accepted in cycle N first appears on o_Data in cycle N+1, provided the fill reaches 8.
- o_Error is registered. It is high in cycle N+1 for an offending accept in cycle N, for exactly one cycle per event.
- When i_Soft_RST and i_Valid coincide, reset wins and the symbol is dropped.
- Reset mid-block discards all buffered bits. The next accepted Gen3 symbol must carry i_Start_Block.

## Structure
- Package phy_tx_pkg holds SYNC_DATA, SYNC_OS, SYMBOL_WIDTH and BLOCK_SYMBOLS. It is shared with the RX block aligner.
- Sub-module tx_bit_accumulator contains acc_q, fill_q, the append/emit logic and the o_Data/o_Valid outputs.
- The top level holds sym_cnt, error detection and back-pressure.

## Test plan
- Reset: assert RST_L low mid-traffic -> all outputs 0 immediately, and fill_q = 0 after release.
- Single Gen3 data block, header 2'b10, symbols 8'h00..8'h0F back-to-back -> first o_Data = 8'h02 one cycle after the first accept; 130 bits out, reconstructed bit-exact; o_Error never set.
- 4 back-to-back blocks -> fill_q reaches 16 after block 4 symbol 0; o_Back_Pressure high for exactly 1 cycle; 64 symbols in, 65 words out.
- i_Start_Block at sym_cnt = 5 -> o_Error pulses once; header inserted; next symbol counted as sym_cnt 1.
- Gen1 mode, i_Symbol = 8'hBC -> o_Data = 8'hBC next cycle; o_Back_Pressure and o_Error stay 0 over 1000 random symbols.
- i_Soft_RST mid-block with fill_q = 12 -> o_Valid = 0 next cycle; a new block restarts cleanly with o_Error = 0.

Source files
------------

// File: rtl/phy_tx_pkg.sv
// rtl/phy_tx_pkg.sv - shared 128b/130b framing constants for the PHY TX/RX lane logic
// Contents: symbol/header/block sizes, accumulator sizing, legal sync header codes
// and a helper that classifies a sync header as legal.
package phy_tx_pkg;

  localparam int SYMBOL_WIDTH  = 8;
  localparam int SYNC_WIDTH    = 2;
  localparam int BLOCK_SYMBOLS = 16;
  localparam int ACC_WIDTH     = 24;
  localparam int FILL_WIDTH    = 5;
  localparam int CNT_WIDTH     = $clog2(BLOCK_SYMBOLS);

  localparam logic [SYNC_WIDTH-1:0] SYNC_DATA = 2'b10;
  localparam logic [SYNC_WIDTH-1:0] SYNC_OS   = 2'b01;

  function automatic logic sync_hdr_legal(input logic [SYNC_WIDTH-1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_OS);
  endfunction

endpackage

// File: rtl/tx_bit_accumulator.sv
// rtl/tx_bit_accumulator.sv - LSB-first bit accumulator packing symbols (+ sync header) into 8-bit words
// Ports: clk, rst_n (async, active-low), soft_rst (sync clear), accept (append this cycle),
//        insert_hdr (prepend sync_hdr ahead of symbol), sync_hdr, symbol,
//        data/valid (registered output word), fill_next (fill level after this edge).
module tx_bit_accumulator
  import phy_tx_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    soft_rst,
  input  logic                    accept,
  input  logic                    insert_hdr,
  input  logic [SYNC_WIDTH-1:0]   sync_hdr,
  input  logic [SYMBOL_WIDTH-1:0] symbol,
  output logic [SYMBOL_WIDTH-1:0] data,
  output logic                    valid,
  output logic [FILL_WIDTH-1:0]   fill_next
);

  logic [ACC_WIDTH-1:0]  acc_q, acc_d, base_acc, app_bits;
  logic [FILL_WIDTH-1:0] fill_q, fill_d, base_fill, app_len;
  logic                  emit, valid_q;

  always_comb begin
    emit      = (fill_q >= FILL_WIDTH'(SYMBOL_WIDTH));
    // Drain first, then append behind whatever is left; bits above fill_q are always zero.
    base_acc  = emit ? (acc_q >> SYMBOL_WIDTH) : acc_q;
    base_fill = emit ? (fill_q - FILL_WIDTH'(SYMBOL_WIDTH)) : fill_q;
    // Header sits in the low bits so it leaves the lane before the symbol.
    app_bits  = insert_hdr ? {{(ACC_WIDTH-SYMBOL_WIDTH-SYNC_WIDTH){1'b0}}, symbol, sync_hdr}
                           : {{(ACC_WIDTH-SYMBOL_WIDTH){1'b0}}, symbol};
    app_len   = insert_hdr ? FILL_WIDTH'(SYMBOL_WIDTH + SYNC_WIDTH) : FILL_WIDTH'(SYMBOL_WIDTH);
    acc_d     = base_acc;
    fill_d    = base_fill;
    if (accept) begin
      acc_d  = base_acc | (app_bits << base_fill);
      fill_d = base_fill + app_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else if (soft_rst) begin
      acc_q   <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      // Registered copy of next cycle's emit so o_Valid comes straight from a flop.
      valid_q <= (fill_d >= FILL_WIDTH'(SYMBOL_WIDTH));
    end
  end

  assign data      = acc_q[SYMBOL_WIDTH-1:0];
  assign valid     = valid_q;
  assign fill_next = fill_d;

endmodule

// File: rtl/tx_block_gearbox.sv
// rtl/tx_block_gearbox.sv - per-lane 128b/130b TX gearbox: sync header insertion and 8-bit word packing
// Ports: CLK, RST_L (async, active-low), i_GEN (1=Gen3, 0=Gen1/2 pass-through), i_Soft_RST (sync clear),
//        i_Valid/i_Symbol/i_Start_Block/i_Sync_Header (symbol stream in, bit 0 first),
//        o_Data/o_Valid (word stream out, bit 0 first), o_Back_Pressure (symbol not accepted),
//        o_Error (one-cycle framing error pulse).
module tx_block_gearbox
  import phy_tx_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST_L,
  input  logic                    i_GEN,
  input  logic                    i_Soft_RST,
  input  logic                    i_Valid,
  input  logic [SYMBOL_WIDTH-1:0] i_Symbol,
  input  logic                    i_Start_Block,
  input  logic [SYNC_WIDTH-1:0]   i_Sync_Header,
  output logic [SYMBOL_WIDTH-1:0] o_Data,
  output logic                    o_Valid,
  output logic                    o_Back_Pressure,
  output logic                    o_Error
);

  logic                  bp_q, err_q, accept, start, err_d;
  logic [CNT_WIDTH-1:0]  sym_cnt, cnt_d;
  logic [FILL_WIDTH-1:0] fill_next;

  always_comb begin
    accept = i_Valid & ~bp_q;
    start  = i_GEN & i_Start_Block;
    err_d  = 1'b0;
    cnt_d  = sym_cnt;
    if (i_GEN && accept) begin
      // Start-block off the boundary, or a boundary without start-block, or an illegal header.
      err_d = (start ^ (sym_cnt == '0)) | (start & ~sync_hdr_legal(i_Sync_Header));
      // A start-block always realigns the count so the next symbol is index 1.
      cnt_d = start ? CNT_WIDTH'(1) : sym_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      sym_cnt <= '0;
      bp_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (i_Soft_RST) begin
      sym_cnt <= '0;
      bp_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sym_cnt <= cnt_d;
      // Evaluated on the next fill so back-pressure is a pure flop output.
      bp_q    <= i_GEN & (fill_next >= FILL_WIDTH'(2 * SYMBOL_WIDTH));
      err_q   <= err_d;
    end
  end

  tx_bit_accumulator u_acc (
    .clk       (CLK),
    .rst_n     (RST_L),
    .soft_rst  (i_Soft_RST),
    .accept    (accept),
    .insert_hdr(start),
    .sync_hdr  (i_Sync_Header),
    .symbol    (i_Symbol),
    .data      (o_Data),
    .valid     (o_Valid),
    .fill_next (fill_next)
  );

  assign o_Back_Pressure = bp_q;
  assign o_Error         = err_q;

endmodule

// File: tb/tb_tx_block_gearbox.sv
// tb/tb_tx_block_gearbox.sv - scoreboard bench for tx_block_gearbox
module tb_tx_block_gearbox;
  import phy_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       gen = 1'b1;
  logic       soft_rst = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] symbol = 8'h00;
  logic       start_block = 1'b0;
  logic [1:0] sync_hdr = 2'b00;
  logic [7:0] data_out;
  logic       valid_out, back_pressure, error_out;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic       bitq[$];
  int words_out = 0, err_seen = 0, bp_seen = 0, exp_err = 0, max_fill = 0, m_cnt = 0;
  int w0, e0, b0, x0;

  always #5 clk = ~clk;

  tx_block_gearbox dut (
    .CLK            (clk),
    .RST_L          (rst_l),
    .i_GEN          (gen),
    .i_Soft_RST     (soft_rst),
    .i_Valid        (valid_in),
    .i_Symbol       (symbol),
    .i_Start_Block  (start_block),
    .i_Sync_Header  (sync_hdr),
    .o_Data         (data_out),
    .o_Valid        (valid_out),
    .o_Back_Pressure(back_pressure),
    .o_Error        (error_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: serial bit queue, LSB first, header bits before symbol bits.
  task automatic model_accept(input logic [7:0] sym, input logic sb, input logic [1:0] hdr);
    logic [7:0] w;
    if (gen) begin
      if (sb) begin
        bitq.push_back(hdr[0]);
        bitq.push_back(hdr[1]);
      end
      if ((sb != (m_cnt == 0)) || (sb && (hdr[0] == hdr[1]))) exp_err++;
      m_cnt = sb ? 1 : (m_cnt + 1) % 16;
    end
    for (int i = 0; i < 8; i++) bitq.push_back(sym[i]);
    while (bitq.size() >= 8) begin
      for (int i = 0; i < 8; i++) w[i] = bitq.pop_front();
      exp_q.push_back(w);
    end
  endtask

  task automatic model_flush();
    bitq.delete();
    exp_q.delete();
    m_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (rst_l) begin
      if (valid_out) begin
        words_out++;
        check_eq("word_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check_eq("word", data_out, exp_q.pop_front());
      end
      if (error_out) err_seen++;
      if (back_pressure) bp_seen++;
      if (int'(dut.u_acc.fill_q) > max_fill) max_fill = int'(dut.u_acc.fill_q);
    end
  end

  task automatic send(input logic [7:0] sym, input logic sb, input logic [1:0] hdr);
    int guard = 0;
    @(negedge clk);
    valid_in = 1'b1;
    symbol = sym;
    start_block = sb;
    sync_hdr = hdr;
    while (back_pressure && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check_eq("bp_timeout", guard, 0);
    model_accept(sym, sb, hdr);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    valid_in = 1'b0;
    start_block = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_block(input logic [7:0] first, input logic [1:0] hdr);
    send(first, 1'b1, hdr);
    for (int i = 1; i < 16; i++) send(first + 8'(i), 1'b0, hdr);
  endtask

  // Soft reset; valid_in is left as the caller set it so a coinciding symbol is dropped.
  task automatic do_soft_reset(input logic g);
    @(negedge clk);
    #1;
    soft_rst = 1'b1;
    gen = g;
    model_flush();
    @(posedge clk);
    #1;
    soft_rst = 1'b0;
    valid_in = 1'b0;
    check_eq("srst_valid", valid_out, 0);
    check_eq("srst_fill", dut.u_acc.fill_q, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data", data_out, 0);
    check_eq("rst_valid", valid_out, 0);
    check_eq("rst_bp", back_pressure, 0);
    check_eq("rst_err", error_out, 0);
    @(negedge clk);
    rst_l = 1'b1;

    // Single Gen3 data block 00..0F
    w0 = words_out; e0 = err_seen;
    send(8'h00, 1'b1, SYNC_DATA);
    @(posedge clk);
    #1;
    check_eq("first_valid", valid_out, 1);
    check_eq("first_data", data_out, 8'h02);
    for (int i = 1; i < 16; i++) send(8'(i), 1'b0, SYNC_DATA);
    idle(4);
    check_eq("blk1_words", words_out - w0, 16);
    check_eq("blk1_leftover", dut.u_acc.fill_q, 2);
    check_eq("blk1_drain", exp_q.size(), 0);
    check_eq("blk1_err", err_seen - e0, 0);

    // Four back-to-back blocks
    do_soft_reset(1'b1);
    w0 = words_out; e0 = err_seen; b0 = bp_seen; max_fill = 0;
    for (int b = 0; b < 4; b++) send_block(8'h40 + 8'(b * 16), (b % 2 == 0) ? SYNC_DATA : SYNC_OS);
    idle(4);
    check_eq("blk4_words", words_out - w0, 65);
    check_eq("blk4_bp", bp_seen - b0, 1);
    check_eq("blk4_maxfill", max_fill, 16);
    check_eq("blk4_fill", dut.u_acc.fill_q, 0);
    check_eq("blk4_drain", exp_q.size(), 0);
    check_eq("blk4_err", err_seen - e0, 0);

    // Framing errors: misplaced start, illegal header, missing start
    do_soft_reset(1'b1);
    e0 = err_seen; x0 = exp_err;
    send(8'hA0, 1'b1, SYNC_OS);
    for (int i = 1; i < 5; i++) send(8'hA0 + 8'(i), 1'b0, SYNC_OS);
    send(8'hB0, 1'b1, SYNC_DATA);
    @(posedge clk);
    #1;
    check_eq("err_pulse", error_out, 1);
    for (int i = 1; i < 16; i++) send(8'hB0 + 8'(i), 1'b0, SYNC_DATA);
    send_block(8'hC0, SYNC_DATA);
    check_eq("realign_err", err_seen - e0, 1);
    send_block(8'hD0, 2'b11);
    send(8'hE0, 1'b0, SYNC_DATA);
    idle(4);
    check_eq("err_count_model", err_seen - e0, exp_err - x0);
    check_eq("err_count", err_seen - e0, 3);
    check_eq("err_drain", exp_q.size(), 0);

    // Gen1/2 pass-through
    do_soft_reset(1'b0);
    e0 = err_seen; b0 = bp_seen; max_fill = 0;
    send(8'hBC, 1'b0, 2'b00);
    @(posedge clk);
    #1;
    check_eq("gen1_valid", valid_out, 1);
    check_eq("gen1_data", data_out, 8'hBC);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) != 0)
        send(8'($urandom), 1'($urandom), 2'($urandom));
      else
        idle(1);
    end
    idle(4);
    check_eq("gen1_bp", bp_seen - b0, 0);
    check_eq("gen1_err", err_seen - e0, 0);
    check_eq("gen1_fill_le8", 32'(max_fill <= 8), 1);
    check_eq("gen1_drain", exp_q.size(), 0);

    // Soft reset mid-block at fill 12, coinciding with a valid symbol
    do_soft_reset(1'b1);
    send_block(8'h10, SYNC_DATA);
    send(8'h20, 1'b1, SYNC_OS);
    send(8'h21, 1'b0, SYNC_OS);
    @(posedge clk);
    #1;
    check_eq("pre_srst_fill", dut.u_acc.fill_q, 12);
    symbol = 8'h55;
    start_block = 1'b0;
    do_soft_reset(1'b1);
    w0 = words_out; e0 = err_seen;
    send_block(8'h30, SYNC_DATA);
    idle(4);
    check_eq("restart_err", err_seen - e0, 0);
    check_eq("restart_words", words_out - w0, 16);
    check_eq("restart_drain", exp_q.size(), 0);

    // Hard reset mid-traffic
    send(8'h60, 1'b1, SYNC_DATA);
    send(8'h61, 1'b0, SYNC_DATA);
    send(8'h62, 1'b0, SYNC_DATA);
    @(posedge clk);
    #2;
    rst_l = 1'b0;
    #1;
    check_eq("hrst_data", data_out, 0);
    check_eq("hrst_valid", valid_out, 0);
    check_eq("hrst_bp", back_pressure, 0);
    check_eq("hrst_err", error_out, 0);
    valid_in = 1'b0;
    model_flush();
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    check_eq("hrst_fill", dut.u_acc.fill_q, 0);
    w0 = words_out; e0 = err_seen;
    send_block(8'h70, SYNC_OS);
    idle(4);
    check_eq("hrst_words", words_out - w0, 16);
    check_eq("hrst_err_after", err_seen - e0, 0);
    check_eq("hrst_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
